// File: rtl/sram_rect_fill.sv
// ---------------------------------------------------------------------------
// sram_rect_fill
//   Fill engine that writes one full frame of 8x8 coloured rectangles into
//   external SRAM. It writes one 16-bit word (two horizontally adjacent
//   pixels) per clock. Colour of a rectangle = (rect_row + rect_col) mod 8.
//
// Ports
//   Clock_50        in   system clock, rising edge
//   Resetn          in   asynchronous active-low reset
//   Start           in   1-cycle start pulse; ignored unless idle
//   Busy            out  high while words are being written
//   Done            out  1-cycle pulse after the last word
//   SRAM_address    out  18-bit word address
//   SRAM_write_data out  {5'd0, c, 5'd0, c}
//   SRAM_we_n       out  active-low write enable
// ---------------------------------------------------------------------------
module sram_rect_fill #(
   parameter int          H_PIXELS    = 320,
   parameter int          V_PIXELS    = 240,
   parameter int          RECT_WIDTH  = 40,
   parameter int          RECT_HEIGHT = 30,
   parameter logic [17:0] BASE_ADDR   = 18'd0
) (
   input  logic        Clock_50,
   input  logic        Resetn,
   input  logic        Start,
   output logic        Busy,
   output logic        Done,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n
);

   localparam int          XW        = $clog2(RECT_WIDTH);
   localparam int          YW        = $clog2(RECT_HEIGHT);
   localparam logic [XW-1:0] X_LAST  = XW'(RECT_WIDTH - 2);
   localparam logic [YW-1:0] Y_LAST  = YW'(RECT_HEIGHT - 1);
   localparam int          N_WORDS   = H_PIXELS * V_PIXELS / 2;
   localparam logic [17:0] LAST_ADDR = 18'(BASE_ADDR + 18'(N_WORDS - 1));

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_FINISH_FILL_SRAM
   } state_t;

   state_t            state_q, state_d;
   logic [XW-1:0]     x_q, x_d;       // pixel offset of the current word inside its rectangle
   logic [YW-1:0]     y_q, y_d;       // line offset inside the rectangle
   logic [2:0]        col_q, col_d;
   logic [2:0]        row_q, row_d;
   logic [17:0]       addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic              we_n_q, we_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // counter values for the word following the one currently presented
   logic [XW-1:0]     x_nx;
   logic [YW-1:0]     y_nx;
   logic [2:0]        col_nx;
   logic [2:0]        row_nx;

   function automatic logic [15:0] pack_word(input logic [2:0] c);
      return {5'd0, c, 5'd0, c};
   endfunction

   // ---------------- state register ----------------
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:             if (Start) state_d = S_FILL;
         S_FILL:             if (addr_q == LAST_ADDR) state_d = S_FINISH_FILL_SRAM;
         S_FINISH_FILL_SRAM: state_d = S_IDLE;
         default:            state_d = S_IDLE;
      endcase
   end

   // Rectangle walk without division: x steps by 2 pixels per word. The
   // 3-bit rect_col wraps 7->0 on its own at end of line since the line is
   // exactly 8 rectangles wide.
   always_comb begin
      x_nx   = x_q + XW'(2);
      y_nx   = y_q;
      col_nx = col_q;
      row_nx = row_q;
      if (x_q == X_LAST) begin
         x_nx   = '0;
         col_nx = col_q + 3'd1;
         if (col_q == 3'd7) begin
            if (y_q == Y_LAST) begin
               y_nx   = '0;
               row_nx = row_q + 3'd1;
            end else begin
               y_nx   = y_q + YW'(1);
            end
         end
      end
   end

   // ---------------- output / datapath next values ----------------
   always_comb begin
      x_d    = '0;
      y_d    = '0;
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
      data_d = '0;
      we_n_d = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               // pixel (0,0) sits in rectangle (0,0) -> colour 0
               addr_d = BASE_ADDR;
               data_d = pack_word(3'd0);
               we_n_d = 1'b0;
               busy_d = 1'b1;
            end
         end
         S_FILL: begin
            if (addr_q == LAST_ADDR) begin
               done_d = 1'b1;
            end else begin
               x_d    = x_nx;
               y_d    = y_nx;
               col_d  = col_nx;
               row_d  = row_nx;
               addr_d = addr_q + 18'd1;
               data_d = pack_word(row_nx + col_nx);
               we_n_d = 1'b0;
               busy_d = 1'b1;
            end
         end
         default: ;  // S_FINISH_FILL_SRAM: everything back to idle values
      endcase
   end

   // ---------------- registered outputs and counters ----------------
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         x_q    <= '0;
         y_q    <= '0;
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         we_n_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         col_q  <= col_d;
         row_q  <= row_d;
         addr_q <= addr_d;
         data_q <= data_d;
         we_n_q <= we_n_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign Busy            = busy_q;
   assign Done            = done_q;
   assign SRAM_address    = addr_q;
   assign SRAM_write_data = data_q;
   assign SRAM_we_n       = we_n_q;

endmodule
